muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for RV32M multiply/divide instructions in the EX stage. It sits beside the single-cycle ALU and accepts an M-extension operation (opcode OP, funct7 = 7'b0000001) with its operands. It iterates over an internal shift/add-subtract datapath and holds the pipeline with a stall until the 32-bit result is ready. Only one operation is in flight at a time. An EX flush aborts it.

## Interface

- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX holds a valid M-extension instruction this cycle.
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  XLEN  operand A, already forwarded.
- rs2_data  in  XLEN  operand B, already forwarded.
- flush  in  1  EX flush (branch/jump redirect); aborts any operation.
- stall  out  1  freeze IF/ID/EX, insert bubble into MEM.
- busy  out  1  FSM not in IDLE.
- done  out  1  result valid this cycle, one-cycle pulse.
- result  out  XLEN  selected product half, quotient or remainder.

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0: latch funct3, take operand magnitudes, record signs, clear the 64-bit accumulator, load count=31, then go to CALC.
  - Signedness: MULH makes both operands signed; MULHSU makes only A signed; DIV/REM make both signed.
  - Divide by zero (B=0) and signed overflow (DIV/REM, A=32'h8000_0000, B=32'hFFFF_FFFF) skip CALC and go straight to DONE with the RISC-V-defined result.
- CALC, one bit per cycle:
  - Multiply: shift-add on the magnitudes into the 64-bit product.
  - Divide: restoring step (shift remainder left, trial subtract, set quotient bit).
  - count decrements each cycle; at count=0 go to FIX.
- FIX:
  - Negate the product when the operand signs differ.
  - Negate the quotient when the signs differ.
  - Give the remainder the sign of the dividend.
  - Go to DONE.
- DONE: done=1, result driven, then return to IDLE.
- Result selection:
  - MUL gives product[31:0].
  - MULH, MULHSU and MULHU give product[63:32].
  - DIV and DIVU give the quotient; REM and REMU give the remainder.
- Special results:
  - DIV or DIVU by 0 gives 32'hFFFF_FFFF. REM or REMU by 0 gives A.
  - Overflow: DIV gives 32'h8000_0000; REM gives 0.
- Operands are sampled only in the start cycle. Later changes on rs1_data, rs2_data and funct3 are ignored.
- start is ignored while busy=1.
- flush:
  - In any state, the FSM goes to IDLE on the next edge and no done is produced.
  - flush together with start in IDLE: start is ignored.
- stall = (start & ~flush in IDLE) | (state is CALC or FIX). stall is 0 in DONE so the pipeline advances with the result.

## Timing

- Reset values: stall=0, busy=0, done=0, result=0, state=IDLE, count=0, accumulators=0.
- Normal latency: start at cycle 0, CALC covers cycles 1–32, FIX is cycle 33, done=1 in cycle 34 (34 stall cycles).
- Special-case latency: done=1 in cycle 1 (one stall cycle).
- result holds its last value after DONE until the next DONE. It is only valid when done=1.
- Reset asserted mid-operation forces the reset values immediately, asynchronously; no done is produced.
- All outputs are registered except stall, which is combinational from start, flush and state.

## Configuration

- MULDIV_FAST_MUL_EN defined: MUL, MULH, MULHSU and MULHU compute a single-cycle 33x33 signed product in IDLE, then go directly to DONE (done in cycle 1). Divide is unchanged.
- MULDIV_FAST_MUL_EN undefined: multiply uses the iterative CALC/FIX path (done in cycle 34).

## Test plan

- MUL A=7, B=-3 (32'hFFFF_FFFD) -> done at cycle 34 (cycle 1 with MULDIV_FAST_MUL_EN), result=32'hFFFF_FFEB; MULHU with the same operands -> 32'h0000_0006.
- DIV A=-7, B=2 -> result=32'hFFFF_FFFD (-3); REM with the same operands -> 32'hFFFF_FFFF (-1); DIVU A=100, B=7 -> 14.
- DIVU A=5, B=0 -> done at cycle 1, result=32'hFFFF_FFFF; REM A=5, B=0 -> 5.
- DIV A=32'h8000_0000, B=32'hFFFF_FFFF -> 32'h8000_0000; REM with the same operands -> 0.
- Start DIV, assert flush at cycle 10 -> busy=0 and stall=0 at cycle 11, no done pulse. A new MUL A=3, B=4 started at cycle 12 -> result 12.
- Assert rst at cycle 20 of a MULH -> all outputs return to reset values immediately. start pulsed while busy -> ignored, and the first result is unaffected.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// EX-stage handshake between the pipeline and the RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_seq (
  input logic        clk,
  input logic        rst,
  muldiv_seq_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      op;
  logic            neg_res;
  logic            neg_rem;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]   count;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [2:0]      f3;
  logic [XLEN-1:0] a, b;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            fast_mul;
  logic [XLEN-1:0] fast_res;

  // Operand decode in the start cycle
  always_comb begin
    f3       = bus.funct3;
    a        = bus.rs1_data;
    b        = bus.rs2_data;
    a_signed = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b110);
    b_signed = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? XLEN'(~a + XLEN'(1)) : a;
    b_mag    = b_neg ? XLEN'(~b + XLEN'(1)) : b;
    div_zero = f3[2] && (b == '0);
    div_ovf  = f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = f3[1] ? a : 32'hFFFF_FFFF;
    else          special_res = f3[1] ? 32'h0000_0000 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_prod;
  assign fast_prod = $signed({{XLEN{a_signed & a[XLEN-1]}}, a}) *
                     $signed({{XLEN{b_signed & b[XLEN-1]}}, b});
  assign fast_mul  = !f3[2];
  assign fast_res  = (f3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul  = 1'b0;
  assign fast_res  = '0;
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  // One shift-add / restoring-divide step; acc low half holds multiplier or dividend/quotient
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : (XLEN+1)'(0));
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, mag_b};
    div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  // Sign correction and result selection
  always_comb begin
    prod_fix = neg_res ? (2*XLEN)'(~acc + (2*XLEN)'(1)) : acc;
    quot_fix = neg_res ? XLEN'(~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_fix  = neg_rem ? XLEN'(~acc[2*XLEN-1:XLEN] + XLEN'(1)) : acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:         fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_res = quot_fix;
      default:        fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op      <= f3;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            mag_a   <= a_mag;
            mag_b   <= b_mag;
            count   <= CW'(31);
            busy_q  <= 1'b1;
            if (special || fast_mul) begin
              result_q <= special ? special_res : fast_res;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              acc   <= {XLEN'(0), f3[2] ? a_mag : b_mag};
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          if (count == '0) state <= FIX;
          else             count <= count - CW'(1);
        end
        FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall  = ((state == IDLE) && bus.start && !bus.flush) ||
                      (state == CALC) || (state == FIX);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; expected values computed by hand.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start an op at a falling edge (cycle 0) and check latency and result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] res;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = b;
    #1 check({tag, ".stall0"}, 32'(bus.stall), 32'd1);
    @(negedge clk);
    bus.start = 1'b0; bus.funct3 = 3'b111;
    bus.rs1_data = $urandom; bus.rs2_data = $urandom;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".res"}, bus.result, exp);
    check({tag, ".stall_done"}, 32'(bus.stall), 32'd0);
    res = bus.result;
    @(negedge clk);
    check({tag, ".pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".hold"}, bus.result, res);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.stall", 32'(bus.stall), 32'd0);
    check("rst.result", bus.result, 32'd0);

    run_op("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhu",  3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, MUL_LAT);
    run_op("mulh",   3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 34);
    run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    run_op("divu0",  3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush mid-divide
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b100; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3;
    seen_done = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen_done++;
      if (i == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    if (bus.done) seen_done++;
    check("flush.busy", 32'(bus.busy), 32'd0);
    check("flush.stall", 32'(bus.stall), 32'd0);
    check("flush.nodone", 32'(seen_done), 32'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);

    // start together with flush in IDLE is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b101;
    bus.rs1_data = 32'd9; bus.rs2_data = 32'd0;
    #1 check("startflush.stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("startflush.busy", 32'(bus.busy), 32'd0);
    check("startflush.done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-MULH
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b001; bus.rs1_data = 32'd7; bus.rs2_data = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.done", 32'(bus.done), 32'd0);
    check("arst.stall", 32'(bus.stall), 32'd0);
    check("arst.result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // start pulsed while busy must not disturb the running divide
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
    seen_done = 0;
    begin
      int lat;
      lat = 0;
      while (!bus.done && lat < 100) begin
        @(negedge clk);
        lat++;
        bus.start = (lat == 5);
        bus.funct3 = 3'b000; bus.rs1_data = 32'd2; bus.rs2_data = 32'd0;
      end
      bus.start = 1'b0;
      check("busystart.lat", 32'(lat), 32'd34);
      check("busystart.res", bus.result, 32'd14);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
